// File: rtl/cam_pkg.sv
// Shared geometry and state encoding for the camera capture path and the VGA-side reader.
package cam_pkg;

  typedef enum logic [1:0] {
    INIT       = 2'd0,
    WAIT_FRAME = 2'd1,
    BYTE1      = 2'd2,
    BYTE2      = 2'd3
  } cam_state_t;

  localparam int RGB444_W  = 12;
  localparam int IMG_W_DEF = 160;
  localparam int IMG_H_DEF = 120;

endpackage

// File: rtl/cam_read.sv
// OV7670 capture front-end: assembles two-byte RGB444 pixels and writes them
// into the frame buffer at a linear, saturating pixel address.
module cam_read
  import cam_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int AW    = 15
) (
  input  logic                CAM_pclk,
  input  logic                rst,
  input  logic                CAM_vsync,
  input  logic                CAM_href,
  input  logic [7:0]          CAM_px_data,
  output logic [AW-1:0]       DP_RAM_addr_in,
  output logic [RGB444_W-1:0] DP_RAM_data_in,
  output logic                DP_RAM_regW,
  output logic                frame_done,
  output logic                overflow
);

  // state      | meaning
  // INIT       | after reset; skip any frame already in progress
  // WAIT_FRAME | vsync blanking, address held at 0
  // BYTE1      | expecting XXXX_RRRR
  // BYTE2      | expecting GGGG_BBBB

  localparam logic [AW-1:0] LAST_ADDR = AW'(IMG_W * IMG_H - 1);

  cam_state_t state, state_nxt;

  logic load_hi, load_lo, wr_req, eof, clr_addr, ovf_set;
  logic full;

  always_ff @(posedge CAM_pclk or posedge rst) begin
    if (rst) state <= INIT;
    else     state <= state_nxt;
  end

  // vsync wins over href so a frame end always closes cleanly, even mid-pixel
  always_comb begin
    state_nxt = state;
    case (state)
      INIT:       if (CAM_vsync)  state_nxt = WAIT_FRAME;
      WAIT_FRAME: if (!CAM_vsync) state_nxt = BYTE1;
      BYTE1: begin
        if (CAM_vsync)     state_nxt = WAIT_FRAME;
        else if (CAM_href) state_nxt = BYTE2;
      end
      BYTE2: begin
        if (CAM_vsync) state_nxt = WAIT_FRAME;
        else           state_nxt = BYTE1;
      end
      default: state_nxt = INIT;
    endcase
  end

  always_comb begin
    load_hi  = 1'b0;
    load_lo  = 1'b0;
    wr_req   = 1'b0;
    eof      = 1'b0;
    clr_addr = 1'b0;
    ovf_set  = 1'b0;
    case (state)
      INIT, WAIT_FRAME: clr_addr = 1'b1;
      BYTE1: begin
        if (CAM_vsync)     eof     = 1'b1;
        else if (CAM_href) load_hi = 1'b1;
      end
      BYTE2: begin
        if (CAM_vsync) eof = 1'b1;
        else if (CAM_href) begin
          load_lo = 1'b1;
          wr_req  = !full;
          ovf_set = full;
        end
      end
      default: clr_addr = 1'b1;
    endcase
  end

  always_ff @(posedge CAM_pclk or posedge rst) begin
    if (rst) begin
      DP_RAM_data_in <= '0;
      DP_RAM_regW    <= 1'b0;
      frame_done     <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      DP_RAM_regW <= wr_req;
      frame_done  <= eof;
      overflow    <= overflow | ovf_set;
      if (load_hi) DP_RAM_data_in[11:8] <= CAM_px_data[3:0];
      if (load_lo) DP_RAM_data_in[7:0]  <= CAM_px_data;
    end
  end

  // address advances after each strobe; once the last pixel is written it
  // parks there and `full` turns further pixels into overflow
  always_ff @(posedge CAM_pclk or posedge rst) begin
    if (rst) begin
      DP_RAM_addr_in <= '0;
      full           <= 1'b0;
    end else if (eof || clr_addr) begin
      DP_RAM_addr_in <= '0;
      full           <= 1'b0;
    end else if (DP_RAM_regW) begin
      if (DP_RAM_addr_in == LAST_ADDR) full <= 1'b1;
      else DP_RAM_addr_in <= DP_RAM_addr_in + AW'(1);
    end
  end

endmodule

// File: doc/cam_read.md
# cam_read

Capture front-end for the OV7670 path: samples the camera's parallel interface (`CAM_vsync`, `CAM_href`, `CAM_px_data`) on the pixel clock. It assembles each two-byte RGB444 pixel and writes it into the dual-port frame buffer at a linear pixel address. It is the receiving end of the camera stimulus used in simulation, and sits between the camera pins and the write port of the DP RAM read out by the VGA driver.

## Interface
- `IMG_W`, 160: pixels per row (320 bytes per `CAM_href` pulse).
- `IMG_H`, 120: rows per frame.
- `AW`, 15: frame-buffer address width; requires `IMG_W*IMG_H <= 2**AW`.
- `CAM_pclk`  in  1  single clock; all logic on its rising edge. Camera data, `CAM_href` and `CAM_vsync` are stable at this edge.
- `rst`  in  1  asynchronous, active-high reset.
- `CAM_vsync`  in  1  high = inter-frame blanking; falling edge = frame start.
- `CAM_href`  in  1  high = valid bytes on the current row.
- `CAM_px_data`  in  8  byte stream. First byte is `XXXX_RRRR`, second byte is `GGGG_BBBB`.
- `DP_RAM_addr_in`  out  AW  linear pixel address, row*IMG_W + col.
- `DP_RAM_data_in`  out  12  RGB444 pixel, `{R,G,B}`.
- `DP_RAM_regW`  out  1  write strobe, one cycle per pixel.
- `frame_done`  out  1  one-cycle pulse at the end of every captured frame.
- `overflow`  out  1  sticky flag: a pixel arrived beyond `IMG_W*IMG_H-1`. Cleared only by reset.

## Operation
- FSM states: `INIT`, `WAIT_FRAME`, `BYTE1`, `BYTE2`.
- `INIT`: wait for `CAM_vsync`=1, then go to `WAIT_FRAME`. A frame already in progress when reset releases is never captured.
- `WAIT_FRAME`: hold address at 0. On `CAM_vsync`=0, go to `BYTE1`.
- `BYTE1`:
  - If `CAM_href`=1: latch `CAM_px_data[3:0]` into `DP_RAM_data_in[11:8]`, then go to `BYTE2`.
  - If `CAM_vsync`=1: pulse `frame_done`, then go to `WAIT_FRAME`.
- `BYTE2`:
  - If `CAM_href`=1: latch `CAM_px_data` into `DP_RAM_data_in[7:0]`, assert `DP_RAM_regW`, then go to `BYTE1`.
  - If `CAM_href`=0: drop the half pixel (no write), then go to `BYTE1`.
- Byte phase is realigned on every row: `CAM_href` low always returns the FSM to `BYTE1`.
- Address handling:
  - Increments by 1 in the cycle after each strobe.
  - Does not reset between rows. Rows are contiguous because each row yields exactly `IMG_W` writes.
  - Saturates: once the address reaches `IMG_W*IMG_H-1`, further pixels in the frame set `overflow`, assert no `DP_RAM_regW`, and leave the address unchanged.
- `CAM_vsync` going high in `BYTE2`: the half pixel is dropped and the end-of-frame handling of `BYTE1` is applied in the same cycle.

## Timing
- Reset values: `INIT`; `DP_RAM_addr_in`=0, `DP_RAM_data_in`=0, `DP_RAM_regW`=0, `frame_done`=0, `overflow`=0.
- Latency: `DP_RAM_regW`, the full `DP_RAM_data_in` and the matching `DP_RAM_addr_in` are valid together in the cycle after the second byte is sampled.
- Addressing: pixel n is written with address n. The following cycle shows address n+1 with `DP_RAM_regW`=0.
- Throughput: one write every 2 `CAM_pclk` cycles while `CAM_href`=1. `DP_RAM_regW` is never asserted in two consecutive cycles.
- `frame_done` is asserted in the cycle after `CAM_vsync` is sampled high. The address reads 0 in that same cycle.
- Asynchronous reset mid-row: the next write occurs only after a full vsync high-then-low sequence.

## Structure
- Shared package `cam_pkg`:
  - FSM state encoding (2 bits);
  - `RGB444_W`=12;
  - defaults for `IMG_W` and `IMG_H`.
  The VGA-side reader uses the same geometry constants.
- No sub-module: a single FSM plus address counter and data register, roughly 150 lines.

## Test plan
- Byte pattern repeating per row `00,0F,00,0F,00,F0,00,F0`, with `CAM_href` for 320 bytes and a 4-byte gap -> writes 0x00F, 0x00F, 0x0F0, 0x0F0 repeating. Row r, col 0 is at address r*160.
- Full frame (4 blank rows with `CAM_vsync` high for the first two, then 120 active rows) -> exactly 19200 strobes at addresses 0..19199 and one `frame_done` pulse when `CAM_vsync` rises. `overflow` stays 0.
- 321-byte row (odd count) -> 160 writes. The trailing byte is dropped and the next row starts at col 0 with no byte-phase slip.
- 121 active rows -> last row produces no writes, the address holds at 19199, and `overflow`=1 until `rst`.
- `rst` pulsed mid-row -> all outputs return to 0 immediately. No writes occur until the next vsync high-to-low, after which the first write is at address 0.
- `CAM_vsync` rising while in `BYTE2` -> no write for the half pixel and `frame_done` pulses once.
